proc_control_unit: RTL and testbench

- FSM controller that sequences the team's 16-bit processor datapath: instruction ROM, the 16x16 register file (synchronous read, 1-cycle latency), the data memory and the ALU.
- Owns the PC and IR.
- Fetches and decodes each instruction, then drives every read address, write strobe and mux select so that each instruction completes in a fixed cycle count.

---
 rtl/proc_control_unit.sv | 136 +++++++++++++
 tb/tb_proc_control_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/proc_control_unit.sv
// rtl/proc_control_unit.sv - FSM sequencer for the 16-bit datapath; owns PC and IR
module proc_control_unit #(
  parameter int PC_W = 7,
  parameter int D_W  = 8
) (
  input  logic            clk,
  input  logic            n_rst,
  output logic [PC_W-1:0] im_addr,
  input  logic [15:0]     im_data,
  output logic [D_W-1:0]  d_addr,
  output logic            d_rd,
  output logic            d_wr,
  output logic [3:0]      rf_ra_addr,
  output logic [3:0]      rf_rb_addr,
  output logic            rf_w_en,
  output logic [3:0]      rf_w_addr,
  output logic            rf_w_sel,
  output logic [1:0]      alu_op,
  output logic [15:0]     ir,
  output logic [3:0]      state,
  output logic            halted,
  output logic            illegal_op
);

  typedef enum logic [3:0] {
    S_INIT    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_NOOP    = 4'd3,
    S_LOAD_A  = 4'd4,
    S_LOAD_B  = 4'd5,
    S_STORE_A = 4'd6,
    S_STORE_B = 4'd7,
    S_ALU_A   = 4'd8,
    S_ALU_B   = 4'd9,
    S_HALT    = 4'd10
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            illegal_q, illegal_d;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      S_INIT:    state_d = S_FETCH;
      S_FETCH: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = S_DECODE;
      end
      // IR is loaded here, so the next state must be chosen from the ROM word itself
      S_DECODE: begin
        ir_d = im_data;
        case (im_data[15:12])
          4'b0000:          state_d = S_NOOP;
          4'b0001:          state_d = S_STORE_A;
          4'b0010:          state_d = S_LOAD_A;
          4'b0011, 4'b0100: state_d = S_ALU_A;
          4'b0101:          state_d = S_HALT;
          default: begin
            state_d   = S_NOOP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_NOOP:    state_d = S_FETCH;
      S_LOAD_A:  state_d = S_LOAD_B;
      S_LOAD_B:  state_d = S_FETCH;
      S_STORE_A: state_d = S_STORE_B;
      S_STORE_B: state_d = S_FETCH;
      S_ALU_A:   state_d = S_ALU_B;
      S_ALU_B:   state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= S_INIT;
      pc_q      <= '0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    d_addr    = '0;
    d_rd      = 1'b0;
    d_wr      = 1'b0;
    rf_w_en   = 1'b0;
    rf_w_addr = ir_q[3:0];
    rf_w_sel  = 1'b0;
    alu_op    = 2'b00;
    halted    = 1'b0;
    case (state_q)
      S_LOAD_A: begin
        d_addr = D_W'(ir_q[11:4]);
        d_rd   = 1'b1;
      end
      S_LOAD_B: begin
        d_addr   = D_W'(ir_q[11:4]);
        d_rd     = 1'b1;
        rf_w_en  = 1'b1;
        rf_w_sel = 1'b1;
      end
      S_STORE_B: begin
        d_addr = D_W'(ir_q[7:0]);
        d_wr   = 1'b1;
      end
      S_ALU_B: begin
        alu_op  = (ir_q[15:12] == 4'b0011) ? 2'b01 : 2'b10;
        rf_w_en = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign im_addr    = pc_q;
  assign rf_ra_addr = ir_q[11:8];
  assign rf_rb_addr = ir_q[7:4];
  assign ir         = ir_q;
  assign state      = state_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_proc_control_unit.sv
// tb/tb_proc_control_unit.sv - per-cycle scoreboard bench for proc_control_unit
module tb_proc_control_unit;

  logic        clk;
  logic        n_rst;
  logic [6:0]  im_addr;
  logic [15:0] im_data;
  logic [7:0]  d_addr;
  logic        d_rd, d_wr;
  logic [3:0]  rf_ra_addr, rf_rb_addr;
  logic        rf_w_en;
  logic [3:0]  rf_w_addr;
  logic        rf_w_sel;
  logic [1:0]  alu_op;
  logic [15:0] ir;
  logic [3:0]  state;
  logic        halted, illegal_op;

  proc_control_unit #(.PC_W(7), .D_W(8)) dut (
    .clk(clk), .n_rst(n_rst), .im_addr(im_addr), .im_data(im_data),
    .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr),
    .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
    .rf_w_en(rf_w_en), .rf_w_addr(rf_w_addr), .rf_w_sel(rf_w_sel),
    .alu_op(alu_op), .ir(ir), .state(state),
    .halted(halted), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] rom [128];
  always @(posedge clk) im_data <= rom[im_addr];

  typedef struct {
    logic [3:0]  st;
    logic [6:0]  ima;
    logic [15:0] ir;
    logic [7:0]  dad;
    logic        drd, dwr, wen;
    logic [3:0]  wad;
    logic        wsel;
    logic [1:0]  op;
    logic        hlt, ill;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic mon_en = 1'b0;

  task automatic push(input logic [3:0] st, input logic [6:0] ima, input logic [15:0] eir,
                      input logic [7:0] dad, input logic drd, input logic dwr,
                      input logic wen, input logic [3:0] wad, input logic wsel,
                      input logic [1:0] op, input logic hlt, input logic ill);
    exp_t e;
    e.st = st; e.ima = ima; e.ir = eir; e.dad = dad; e.drd = drd; e.dwr = dwr;
    e.wen = wen; e.wad = wad; e.wsel = wsel; e.op = op; e.hlt = hlt; e.ill = ill;
    exp_q.push_back(e);
  endtask

  // Monitor: one expected row per cycle; don't-care fields only checked under their strobe
  always @(negedge clk) begin
    if (mon_en && exp_q.size() > 0) begin
      exp_t e;
      logic bad;
      e = exp_q.pop_front();
      bad = (state !== e.st) || (im_addr !== e.ima) || (ir !== e.ir) ||
            (d_rd !== e.drd) || (d_wr !== e.dwr) || (rf_w_en !== e.wen) ||
            (alu_op !== e.op) || (halted !== e.hlt) || (illegal_op !== e.ill) ||
            (rf_ra_addr !== e.ir[11:8]) || (rf_rb_addr !== e.ir[7:4]) ||
            ((e.drd || e.dwr) && (d_addr !== e.dad)) ||
            (e.wen && ((rf_w_addr !== e.wad) || (rf_w_sel !== e.wsel)));
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL cycle%0d: got st=%0d im=%0d ir=%h da=%h rd=%b wr=%b we=%b wa=%0d ws=%b op=%b h=%b il=%b ra=%0d rb=%0d | want st=%0d im=%0d ir=%h da=%h rd=%b wr=%b we=%b wa=%0d ws=%b op=%b h=%b il=%b",
                 cyc, state, im_addr, ir, d_addr, d_rd, d_wr, rf_w_en, rf_w_addr, rf_w_sel,
                 alu_op, halted, illegal_op, rf_ra_addr, rf_rb_addr,
                 e.st, e.ima, e.ir, e.dad, e.drd, e.dwr, e.wen, e.wad, e.wsel, e.op, e.hlt, e.ill);
      end
      cyc++;
    end
  end

  initial begin
    logic [15:0] prev;
    int budget;
    n_rst = 1'b0;
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    rom[0] = 16'h2053; rom[1] = 16'h3124; rom[2] = 16'h4451;
    rom[3] = 16'h14A7; rom[4] = 16'h5000;

    // Reset, start a LOAD, reset again mid-LOAD_B for 3 edges
    push(0, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    push(1, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    push(2, 1, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    push(4, 1, 16'h2053, 8'h05, 1, 0, 0, 0, 0, 2'b00, 0, 0);
    push(5, 1, 16'h2053, 8'h05, 1, 0, 1, 3, 1, 2'b00, 0, 0);
    repeat (3) push(0, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    // LOAD 2053
    push(1, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    push(2, 1, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    push(4, 1, 16'h2053, 8'h05, 1, 0, 0, 0, 0, 2'b00, 0, 0);
    push(5, 1, 16'h2053, 8'h05, 1, 0, 1, 3, 1, 2'b00, 0, 0);
    // ADD 3124
    push(1, 1, 16'h2053, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    push(2, 2, 16'h2053, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    push(8, 2, 16'h3124, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    push(9, 2, 16'h3124, 8'h00, 0, 0, 1, 4, 0, 2'b01, 0, 0);
    // SUB 4451
    push(1, 2, 16'h3124, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    push(2, 3, 16'h3124, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    push(8, 3, 16'h4451, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    push(9, 3, 16'h4451, 8'h00, 0, 0, 1, 1, 0, 2'b10, 0, 0);
    // STORE 14A7
    push(1, 3, 16'h4451, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    push(2, 4, 16'h4451, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    push(6, 4, 16'h14A7, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    push(7, 4, 16'h14A7, 8'hA7, 0, 1, 0, 0, 0, 2'b00, 0, 0);
    // HALT 5000, held 20 cycles, then reset
    push(1, 4, 16'h14A7, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    push(2, 5, 16'h14A7, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    repeat (20) push(10, 5, 16'h5000, 8'h00, 0, 0, 0, 0, 0, 2'b00, 1, 0);
    push(0, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 0);

    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1; n_rst = 1'b1;
    repeat (4) @(posedge clk);
    #1 n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (38) @(posedge clk);
    #1 n_rst = 1'b0;
    @(posedge clk);
    #1;
    // Illegal F123 at PC 0, then NOOPs all the way round to the wrap
    rom[0] = 16'hF123;
    for (int i = 1; i < 128; i++) rom[i] = 16'h0000;
    push(1, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    push(2, 1, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    push(3, 1, 16'hF123, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 1);
    prev = 16'hF123;
    for (int p = 1; p < 128; p++) begin
      push(1, 7'(p), prev, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 1);
      push(2, 7'((p + 1) % 128), prev, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 1);
      push(3, 7'((p + 1) % 128), 16'h0000, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 1);
      prev = 16'h0000;
    end
    push(1, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 1);
    push(2, 1, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 1);
    push(3, 1, 16'hF123, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 1);
    n_rst = 1'b1;

    budget = 0;
    while (exp_q.size() > 0 && budget < 2000) begin
      @(negedge clk);
      #1 budget++;
    end
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d rows left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
